dot_product_ctrl: RTL and testbench
===================================

Name: dot_product_ctrl

Overview:
Sequencer for the dot-product datapath. On `start` it drives a shared read address into two vector memories (A and B) through the mem_reader path. It multiply-accumulates the returned word pairs and pushes the final sum into the result FIFO, honouring FIFO backpressure. It sits between the top-level control FSM and the mem_reader/FIFO datapath.

Parameters:
- DATA_WIDTH, 32, width of each vector element (unsigned).
- ADDR_WIDTH, 5, memory address width; maximum vector length is 2**ADDR_WIDTH.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH, accumulator and result width; sized so a full-length sum never overflows.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin; sampled only in IDLE.
- len  in  ADDR_WIDTH+1  number of elements; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  out  1  one-cycle pulse after the result is written.
- read_en  out  1  read strobe to both memories.
- read_address  out  ADDR_WIDTH  shared element index.
- data_a  in  DATA_WIDTH  memory A read data; valid 1 cycle after read_en.
- data_b  in  DATA_WIDTH  memory B read data; valid 1 cycle after read_en.
- fifo_full  in  1  result FIFO full flag.
- fifo_wr_en  out  1  result FIFO write strobe.
- fifo_din  out  ACC_WIDTH  result word.

Behaviour:
- Clocking and reset: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE; busy, done, read_en, fifo_wr_en = 0; read_address=0; fifo_din=0; accumulator=0. All outputs are registered.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - On start=1, latch len_q = min(len, 2**ADDR_WIDTH) and clear acc.
  - If len_q=0, go to WRITE; otherwise go to READ with idx=0.
- READ:
  - read_en=1, read_address=idx.
  - idx increments every cycle. When idx==len_q-1 is issued, go to DRAIN.
- Capture and accumulate:
  - valid_d = read_en delayed 1 cycle.
  - When valid_d=1, acc <= acc + data_a*data_b (full-width unsigned product, zero-extended to ACC_WIDTH).
- DRAIN: one cycle, read_en=0; the last product is accumulated. Go to WRITE.
- WRITE:
  - If fifo_full=0: fifo_wr_en=1 for exactly one cycle, fifo_din=acc, go to DONE.
  - If fifo_full=1: stay in WRITE, fifo_wr_en=0, fifo_din held stable. No write is ever issued while full.
- DONE: done=1 for one cycle, go to IDLE. busy drops in the following cycle.
- Latency for N≥1 with no backpressure (start accepted at edge 0):
  - read_en high for edges 1..N, addresses 0..N-1.
  - DRAIN at edge N+1.
  - fifo_wr_en at edge N+2.
  - done at edge N+3.
- start while not in IDLE is ignored. len changes after latching are ignored.
- Address wrap: never occurs. For len_q=2**ADDR_WIDTH the final address is 2**ADDR_WIDTH-1.
- Reset mid-operation: immediate return to IDLE. No partial result is written and no done pulse is issued.

Decomposition:
- dot_product_pkg holds the state enum (IDLE, READ, DRAIN, WRITE, DONE) and an acc_width(data_w, addr_w) constant function.
- One natural sub-module: dp_mac. It takes clk, rst, clr, valid, a, b and produces acc, i.e. the registered multiply-accumulate. The FSM, counter and FIFO handshake remain in dot_product_ctrl.

Test Plan:
1. Basic sum: len=4, A={1,2,3,4}, B={5,6,7,8}, fifo_full=0 → addresses 0..3 on 4 consecutive cycles; one fifo_wr_en with fifo_din=70 at start+6; done pulse at start+7; busy low afterwards.
2. Zero length: len=0 → no read_en; single fifo_wr_en with fifo_din=0; done follows one cycle later.
3. Backpressure: len=2, A={3,3}, B={4,4}; fifo_full held high for 3 cycles on WRITE entry → fifo_wr_en stays 0 for those cycles, then pulses once with fifo_din=24 and a stable value throughout; done on the next cycle.
4. Full length, max values: len=32, all A=B=32'hFFFFFFFF → fifo_din = 32*(2**32-1)**2 exactly, with no overflow; last address 31; len=40 also clamps to 32 reads.
5. Start while busy: second start pulse during READ → ignored; exactly one result written and one done.
6. Reset mid-READ: assert rst at idx=2 of len=4 → all outputs 0 asynchronously, no fifo_wr_en. After release, a new start with len=1, A={9}, B={9} yields fifo_din=81.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot-product sequencer.
//   state_t   : sequencer state encoding
//   acc_width : accumulator width that cannot overflow for a full-length sum
package dot_product_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Each product needs 2*data_w bits; summing up to 2**addr_w of them adds addr_w bits.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned addr_w);
    return 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/dp_mac.sv
// Registered unsigned multiply-accumulate.
//   clk, rst : clock, asynchronous active-high reset (acc -> 0)
//   clr      : synchronous clear of the accumulator (wins over valid)
//   valid    : add a*b into acc this cycle
//   a, b     : unsigned operands
//   acc      : running sum
module dp_mac #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 69
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (valid) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: reads len element pairs from memories A and B over a
// shared address, accumulates their products and writes the sum to the result
// FIFO, waiting while the FIFO is full.
//   clk, rst              : clock, asynchronous active-high reset
//   start, len            : request and element count (clamped to 2**ADDR_WIDTH)
//   busy, done            : activity flag, one-cycle completion pulse
//   read_en, read_address : memory read strobe and element index
//   data_a, data_b        : memory read data, valid one cycle after read_en
//   fifo_full             : result FIFO backpressure
//   fifo_wr_en, fifo_din  : result FIFO write strobe and data
module dot_product_ctrl
  import dot_product_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [ACC_WIDTH-1:0]  fifo_din
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;
  logic                  valid_d;
  logic                  acc_clr;
  logic                  last_addr;
  logic [ACC_WIDTH-1:0]  acc;

  always_comb begin
    acc_clr   = (state == IDLE) && start;
    last_addr = ({1'b0, read_address} == (len_q - ONE));
  end

  // Read data lands one cycle after the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_d <= 1'b0;
    end else begin
      valid_d <= read_en;
    end
  end

  dp_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .valid(valid_d),
    .a    (data_a),
    .b    (data_b),
    .acc  (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_en      <= 1'b0;
      read_address <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      len_q        <= '0;
    end else begin
      done       <= 1'b0;
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays up through the done cycle and drops on the first IDLE edge.
          busy <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            len_q <= (len > MAX_LEN) ? MAX_LEN : len;
            if (len == '0) begin
              state <= WRITE;
            end else begin
              state        <= READ;
              read_en      <= 1'b1;
              read_address <= '0;
            end
          end
        end
        READ: begin
          if (last_addr) begin
            read_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            read_address <= read_address + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          state <= WRITE;
        end
        WRITE: begin
          if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            fifo_din   <= acc;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
module tb_dot_product_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned ACCW = 69;

  logic            clk;
  logic            rst;
  logic            start;
  logic [AW:0]     len;
  logic            busy;
  logic            done;
  logic            read_en;
  logic [AW-1:0]   read_address;
  logic [DW-1:0]   data_a;
  logic [DW-1:0]   data_b;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [ACCW-1:0] fifo_din;

  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];

  int compared   = 0;
  int mismatched = 0;

  dot_product_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ACC_WIDTH (ACCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .read_en     (read_en),
    .read_address(read_address),
    .data_a      (data_a),
    .data_b      (data_b),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data one cycle after read_en.
  always @(posedge clk) begin
    if (read_en) begin
      data_a <= mem_a[read_address];
      data_b <= mem_b[read_address];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation; outputs sampled 1 time unit after each edge e, where the
  // start is accepted at edge 0.
  task automatic run_op(input string tag, input int n_req, input int full_cyc,
                        input logic [ACCW-1:0] exp_sum, input bit extra_start);
    int n, wr_entry, wr_edge, done_edge;
    int reads, writes, dones, wr_seen, done_seen;
    bit addr_err, busy_err, stall_err;
    logic [ACCW-1:0] din_hold, din_seen;
    logic [AW-1:0]   last_addr;
    n         = (n_req > 32) ? 32 : n_req;
    wr_entry  = (n == 0) ? 0 : n + 1;
    wr_edge   = wr_entry + 1 + full_cyc;
    done_edge = wr_edge + 1;
    reads = 0; writes = 0; dones = 0; wr_seen = -1; done_seen = -1;
    addr_err = 0; busy_err = 0; stall_err = 0;
    din_hold = '0; din_seen = '0; last_addr = '0;
    len   = (AW+1)'(n_req);
    start = 1'b1;
    for (int e = 0; e <= done_edge + 2; e++) begin
      tick();
      if (e == 0) begin
        start = 1'b0;
        len   = (AW+1)'($urandom_range(0, 63));
      end
      if (extra_start) start = (e == 2);
      fifo_full = (e >= wr_entry) && (e < wr_entry + full_cyc);
      if (read_en === 1'b1) begin
        if (read_address !== AW'(reads)) addr_err = 1;
        last_addr = read_address;
        reads++;
      end
      if (fifo_wr_en === 1'b1) begin
        writes++;
        wr_seen  = e;
        din_seen = fifo_din;
      end
      if (done === 1'b1) begin
        dones++;
        done_seen = e;
      end
      if (busy !== (e <= done_edge)) busy_err = 1;
      if (e == wr_entry) din_hold = fifo_din;
      if (e > wr_entry && e < wr_edge && (fifo_wr_en !== 1'b0 || fifo_din !== din_hold))
        stall_err = 1;
    end
    start = 1'b0;
    fifo_full = 1'b0;
    check({tag, ".reads"}, reads, n);
    check({tag, ".addr_seq"}, addr_err, 0);
    if (n > 0) check({tag, ".last_addr"}, last_addr, n - 1);
    check({tag, ".writes"}, writes, 1);
    check({tag, ".wr_edge"}, wr_seen, wr_edge);
    check({tag, ".fifo_din"}, din_seen, exp_sum);
    check({tag, ".dones"}, dones, 1);
    check({tag, ".done_edge"}, done_seen, done_edge);
    check({tag, ".busy"}, busy_err, 0);
    check({tag, ".stall"}, stall_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; fifo_full = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (2) tick();
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.read_en", read_en, 0);
    check("reset.read_address", read_address, 0);
    check("reset.fifo_wr_en", fifo_wr_en, 0);
    check("reset.fifo_din", fifo_din, 0);
    rst = 1'b0;
    tick();

    // Basic sum: 1*5 + 2*6 + 3*7 + 4*8 = 70
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
    mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
    run_op("basic", 4, 0, 69'd70, 1'b0);

    // Zero length
    run_op("zero_len", 0, 0, 69'd0, 1'b0);

    // Backpressure: 3*4 + 3*4 = 24, FIFO full for 3 cycles
    mem_a[0] = 3; mem_a[1] = 3; mem_b[0] = 4; mem_b[1] = 4;
    run_op("backpressure", 2, 3, 69'd24, 1'b0);

    // Full length, max values: 32*(2**32-1)**2 = 2**69 - 2**38 + 32
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 32'hFFFF_FFFF;
      mem_b[i] = 32'hFFFF_FFFF;
    end
    run_op("full_len", 32, 0, 69'h1F_FFFF_FFC0_0000_0020, 1'b0);
    run_op("clamp_len40", 40, 0, 69'h1F_FFFF_FFC0_0000_0020, 1'b0);

    // Start while busy is ignored
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3; mem_a[3] = 4;
    mem_b[0] = 5; mem_b[1] = 6; mem_b[2] = 7; mem_b[3] = 8;
    run_op("start_busy", 4, 0, 69'd70, 1'b1);
    tick();

    // Reset mid-READ at idx=2
    len = 6'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midrst.pre_addr", read_address, 2);
    rst = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.read_en", read_en, 0);
    check("midrst.read_address", read_address, 0);
    check("midrst.fifo_din", fifo_din, 0);
    begin
      int wr_cnt, done_cnt;
      wr_cnt = 0; done_cnt = 0;
      for (int e = 0; e < 3; e++) begin
        tick();
        if (fifo_wr_en !== 1'b0) wr_cnt++;
        if (done !== 1'b0) done_cnt++;
      end
      rst = 1'b0;
      for (int e = 0; e < 3; e++) begin
        tick();
        if (fifo_wr_en !== 1'b0) wr_cnt++;
        if (done !== 1'b0) done_cnt++;
      end
      check("midrst.no_write", wr_cnt, 0);
      check("midrst.no_done", done_cnt, 0);
    end
    mem_a[0] = 9; mem_b[0] = 9;
    run_op("rst_recover", 1, 0, 69'd81, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
